// File: rtl/cpu_boot_sequencer_if.sv
// Host byte channel plus CPU load/reset port of the boot sequencer.
// master = host/testbench side, slave = sequencer side.
interface cpu_boot_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cpu_reset;
    logic [7:0] cpu_input;
    logic [4:0] load_address;
    logic       load;
    logic       is_instruction;

    modport master (
        output in_valid, in_data,
        input  in_ready, cpu_reset, cpu_input,
        input  load_address, load, is_instruction
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, cpu_reset, cpu_input,
        output load_address, load, is_instruction
    );
endinterface

// File: rtl/cpu_boot_sequencer.sv
// Framed byte-stream loader and run controller for the 8-bit CPU.
// Loads IMEM/DMEM with the CPU parked, then runs it for run_len cycles.
module cpu_boot_sequencer #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    cpu_boot_sequencer_if.slave bus,
    output logic busy,
    output logic done,
    output logic error
);

    typedef enum logic [3:0] {
        IDLE, HDR_I, HDR_D, HDR_R, LOAD_I,
        LOAD_D, SETTLE, RUN, DONE, ERROR
    } state_t;

    state_t     state, nxt;
    logic [5:0] n_instr;
    logic [4:0] n_data;
    logic [7:0] run_len;
    logic [7:0] run_cnt;
    logic [4:0] addr;
    logic       xfer, kill, busy_st;
    logic       last_i, last_d;

    always_comb begin
        xfer    = bus.in_valid & bus.in_ready;
        busy_st = (state != IDLE) && (state != DONE)
                  && (state != ERROR);
        kill    = abort & busy_st;
        last_i  = ({1'b0, addr} == (n_instr - 6'd1));
        last_d  = (addr == (n_data - 5'd1));
        nxt     = state;
        unique case (state)
            IDLE, DONE, ERROR:
                if (start && !abort) nxt = HDR_I;
            HDR_I:
                if (xfer) begin
                    if (bus.in_data == 8'd0 ||
                        bus.in_data > 8'(IMEM_DEPTH))
                        nxt = ERROR;
                    else
                        nxt = HDR_D;
                end
            HDR_D:
                if (xfer)
                    nxt = (bus.in_data > 8'(DMEM_DEPTH))
                          ? ERROR : HDR_R;
            HDR_R:
                if (xfer) nxt = LOAD_I;
            LOAD_I:
                if (xfer && last_i)
                    nxt = (n_data == 5'd0) ? SETTLE : LOAD_D;
            LOAD_D:
                if (xfer && last_d) nxt = SETTLE;
            SETTLE:
                nxt = RUN;
            RUN:
                if (run_cnt == 8'd1) nxt = DONE;
            default:
                nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            bus.in_ready       <= 1'b0;
            bus.cpu_reset      <= 1'b1;
            bus.load           <= 1'b0;
            bus.cpu_input      <= 8'd0;
            bus.load_address   <= 5'd0;
            bus.is_instruction <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            n_instr            <= 6'd0;
            n_data             <= 5'd0;
            run_len            <= 8'd0;
            run_cnt            <= 8'd0;
            addr               <= 5'd0;
        end else begin
            state         <= nxt;
            bus.in_ready  <= (nxt == HDR_I) || (nxt == HDR_D)
                             || (nxt == HDR_R) || (nxt == LOAD_I)
                             || (nxt == LOAD_D);
            bus.cpu_reset <= (nxt != RUN);
            busy          <= (nxt != IDLE) && (nxt != DONE)
                             && (nxt != ERROR);
            done          <= (nxt == DONE);
            error         <= (nxt == ERROR);
            bus.load      <= 1'b0;

            if (xfer && !kill) begin
                unique case (state)
                    HDR_I: n_instr <= bus.in_data[5:0];
                    HDR_D: n_data  <= bus.in_data[4:0];
                    HDR_R: begin
                        run_len <= bus.in_data;
                        addr    <= 5'd0;
                    end
                    LOAD_I: begin
                        bus.load           <= 1'b1;
                        bus.cpu_input      <= bus.in_data;
                        bus.load_address   <= addr;
                        bus.is_instruction <= 1'b1;
                        addr <= last_i ? 5'd0 : addr + 5'd1;
                    end
                    LOAD_D: begin
                        bus.load           <= 1'b1;
                        bus.cpu_input      <= bus.in_data;
                        bus.load_address   <= {1'b0, addr[3:0]};
                        bus.is_instruction <= 1'b0;
                        addr <= addr + 5'd1;
                    end
                    default: ;
                endcase
            end

            // run_len of 0 decrements through 255..1, giving 256 cycles
            if (state == SETTLE)
                run_cnt <= run_len;
            else if (state == RUN)
                run_cnt <= run_cnt - 8'd1;

            if (kill) begin
                n_instr <= 6'd0;
                n_data  <= 5'd0;
                run_len <= 8'd0;
                run_cnt <= 8'd0;
                addr    <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed table-driven bench for cpu_boot_sequencer.
// Expected values are written out by hand per cycle.
module tb_cpu_boot_sequencer;

    logic clk = 1'b0;
    logic reset, start, abort, busy, done, error;

    cpu_boot_sequencer_if bus ();

    cpu_boot_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, ab, v;
        logic [7:0] d;
        logic       rdy, cr, ld;
        logic [7:0] din;
        logic [4:0] la;
        logic       isi, bz, dn, er;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic row(input logic st, ab, v,
                       input logic [7:0] d,
                       input logic rdy, cr, ld,
                       input logic [7:0] din,
                       input logic [4:0] la,
                       input logic isi, bz, dn, er);
        vec_t r;
        r.st = st; r.ab = ab; r.v = v; r.d = d;
        r.rdy = rdy; r.cr = cr; r.ld = ld;
        r.din = din; r.la = la; r.isi = isi;
        r.bz = bz; r.dn = dn; r.er = er;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic s, a, v,
                         input logic [7:0] d);
        start = s; abort = a;
        bus.in_valid = v; bus.in_data = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name,
            {8'd0, bus.in_ready, bus.cpu_reset, bus.load,
             bus.cpu_input, bus.load_address,
             bus.is_instruction, busy, done, error},
            {8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    function automatic logic [31:0] flags;
        return {26'd0, bus.in_ready, bus.cpu_reset,
                bus.load, busy, done, error};
    endfunction

    task automatic send(input logic [7:0] b);
        drive(0, 0, 1, b);
        tick;
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick; tick;
        chk_reset_vals("reset_values");
        reset = 1'b0;

        // Test 1: {2,1,3,A1,B2,07}, valid held
        row(1,0,0,8'h00, 0,1,0,8'h00,0,0, 0,0,0);
        row(0,0,1,8'h02, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h01, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h03, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'hA1, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'hB2, 1,1,1,8'hA1,0,1, 1,0,0);
        row(0,0,1,8'h07, 1,1,1,8'hB2,1,1, 1,0,0);
        row(0,0,0,8'h00, 0,1,1,8'h07,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,1,0,8'h00,0,0, 0,1,0);
        // Test 4: same frame, valid toggling
        row(1,0,0,8'h00, 0,1,0,8'h00,0,0, 0,1,0);
        row(0,0,1,8'h02, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h01, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h03, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'hA1, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 1,1,1,8'hA1,0,1, 1,0,0);
        row(0,0,1,8'hB2, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 1,1,1,8'hB2,1,1, 1,0,0);
        row(0,0,1,8'h07, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'hFF, 0,1,1,8'h07,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,0,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,1,0,8'h00,0,0, 0,1,0);
        // Test 3: header errors (33, then n_data 17, then 0)
        row(1,0,0,8'h00, 0,1,0,8'h00,0,0, 0,1,0);
        row(0,0,1,8'h21, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h05, 0,1,0,8'h00,0,0, 0,0,1);
        row(1,0,0,8'h00, 0,1,0,8'h00,0,0, 0,0,1);
        row(0,0,1,8'h01, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,1,8'h11, 1,1,0,8'h00,0,0, 1,0,0);
        row(1,0,0,8'h00, 0,1,0,8'h00,0,0, 0,0,1);
        row(0,0,1,8'h00, 1,1,0,8'h00,0,0, 1,0,0);
        row(0,0,0,8'h00, 0,1,0,8'h00,0,0, 0,0,1);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].v, vecs[i].d);
            checks++;
            if (flags() !== {26'd0, vecs[i].rdy, vecs[i].cr,
                             vecs[i].ld, vecs[i].bz,
                             vecs[i].dn, vecs[i].er}) begin
                errors++;
                $display("FAIL vec%0d flags: got %b expected %b",
                         i, flags()[5:0],
                         {vecs[i].rdy, vecs[i].cr, vecs[i].ld,
                          vecs[i].bz, vecs[i].dn, vecs[i].er});
            end
            if (vecs[i].ld)
                chk($sformatf("vec%0d load_data", i),
                    {18'd0, bus.cpu_input, bus.load_address,
                     bus.is_instruction},
                    {18'd0, vecs[i].din, vecs[i].la, vecs[i].isi});
            tick;
        end

        // Test 2: {1,0,0,55}: no data phase, 256-cycle run
        drive(1, 0, 0, 0); tick;
        send(8'h01); send(8'h00); send(8'h00); send(8'h55);
        drive(0, 0, 0, 0);
        chk("t2_load",
            {bus.in_ready, bus.load, bus.cpu_input,
             bus.load_address, bus.is_instruction},
            {1'b0, 1'b1, 8'h55, 5'd0, 1'b1});
        n = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (!bus.cpu_reset) n++;
            tick;
        end
        chk("t2_run_cycles", n, 256);
        chk("t2_done", {done, bus.cpu_reset}, 2'b11);

        // Test 5: abort in LOAD_I after first instruction byte
        drive(1, 0, 0, 0); tick;
        send(8'h02); send(8'h01); send(8'h03); send(8'hA1);
        drive(0, 1, 0, 0);
        chk("t5_inflight", {bus.load, bus.cpu_input},
            {1'b1, 8'hA1});
        tick;
        drive(0, 0, 0, 0);
        chk("t5_abort", flags(), 32'b010000);
        drive(1, 1, 0, 0); tick;
        drive(0, 0, 0, 0);
        chk("start_abort_idle", flags(), 32'b010000);

        // Test 6: reset mid-RUN, then 1 instr + 16 data
        drive(1, 0, 0, 0); tick;
        send(8'h01); send(8'h00); send(8'd20); send(8'h33);
        drive(0, 0, 0, 0);
        tick; tick; tick;
        chk("t6_in_run", {bus.cpu_reset, busy}, 2'b01);
        reset = 1'b1;
        tick;
        chk_reset_vals("t6_reset_mid_run");
        reset = 1'b0;
        drive(1, 0, 0, 0); tick;
        send(8'h01); send(8'd16); send(8'h01); send(8'h40);
        chk("t6_instr",
            {bus.load, bus.cpu_input, bus.load_address,
             bus.is_instruction},
            {1'b1, 8'h40, 5'd0, 1'b1});
        for (int i = 0; i < 16; i++) begin
            send(8'h80 + 8'(i));
            chk($sformatf("t6_data%0d", i),
                {bus.in_ready, bus.load, bus.cpu_input,
                 bus.load_address, bus.is_instruction},
                {(i < 15), 1'b1, 8'h80 + 8'(i),
                 5'(i), 1'b0});
        end
        drive(0, 0, 0, 0);
        tick;
        chk("t6_run", {bus.cpu_reset, busy, done}, 3'b010);
        tick;
        chk("t6_done", {bus.cpu_reset, busy, done}, 3'b101);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
